// File: rtl/cachepkg.sv
// rtl/cachepkg.sv - shared types for the cache port arbiter
package cachepkg;

  typedef enum logic [1:0] {
    INST_NOP   = 2'd0,
    INST_READ  = 2'd1,
    INST_WRITE = 2'd2,
    INST_FLUSH = 2'd3
  } inst_t;

  localparam inst_t NOP_INST = INST_NOP;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/cache_rr_arbiter.sv
// rtl/cache_rr_arbiter.sv - combinational winner select, round-robin or fixed priority
module cache_rr_arbiter
  import cachepkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int ARB_MODE = 0,
  localparam int ID_W    = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [ID_W-1:0]   last_grant,
  output logic [NUM_CH-1:0] grant,
  output logic [ID_W-1:0]   grant_idx
);

  localparam arb_mode_t MODE = (ARB_MODE == 1) ? ARB_FIXED : ARB_RR;

  int              slot;
  logic [ID_W-1:0] cand;

  // Scan from the farthest candidate to the nearest so the nearest active one wins.
  always_comb begin
    grant_idx = '0;
    slot      = 0;
    cand      = '0;
    if (MODE == ARB_FIXED) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (req[i]) grant_idx = ID_W'(i);
      end
    end else begin
      for (int i = NUM_CH; i >= 1; i--) begin
        slot = (int'(last_grant) + i) % NUM_CH;
        cand = ID_W'(slot);
        if (req[cand]) grant_idx = cand;
      end
    end
    grant = (|req) ? (NUM_CH'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// rtl/cache_port_arbiter.sv - shares one cache port among NUM_CH 4-phase masters
module cache_port_arbiter
  import cachepkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 32,
  parameter int ARB_MODE = 0,
  localparam int ID_W    = $clog2(NUM_CH)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_CH-1:0]              m_request,
  input  inst_t [NUM_CH-1:0]             m_operation,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]  m_addr,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  m_wdata,
  output logic [NUM_CH-1:0]              m_valid,
  output logic [NUM_CH-1:0]              m_evict,
  output logic [DATA_W-1:0]              m_rdata,
  output logic                           s_request,
  output inst_t                          s_operation,
  output logic [ADDR_W-1:0]              s_addr,
  output logic [DATA_W-1:0]              s_wdata,
  input  logic                           s_valid,
  input  logic                           s_evict,
  input  logic [DATA_W-1:0]              s_rdata,
  output logic [ID_W-1:0]                grant_id,
  output logic                           busy
);

  arb_state_t        state, state_d;
  logic [ID_W-1:0]   last_grant, last_grant_d, grant_id_d, arb_idx;
  logic [NUM_CH-1:0] gnt_oh, gnt_oh_d, arb_oh, m_valid_d, m_evict_d;
  logic [DATA_W-1:0] m_rdata_d, s_wdata_d;
  logic [ADDR_W-1:0] s_addr_d;
  inst_t             s_operation_d;
  logic              s_request_d, busy_d;

  cache_rr_arbiter #(.NUM_CH(NUM_CH), .ARB_MODE(ARB_MODE)) u_arb (
    .req        (m_request),
    .last_grant (last_grant),
    .grant      (arb_oh),
    .grant_idx  (arb_idx)
  );

  always_comb begin
    state_d       = state;
    last_grant_d  = last_grant;
    grant_id_d    = grant_id;
    gnt_oh_d      = gnt_oh;
    m_valid_d     = m_valid;
    m_evict_d     = m_evict;
    m_rdata_d     = m_rdata;
    s_request_d   = s_request;
    s_operation_d = s_operation;
    s_addr_d      = s_addr;
    s_wdata_d     = s_wdata;
    case (state)
      ST_IDLE: begin
        if (|m_request) begin
          grant_id_d    = arb_idx;
          last_grant_d  = arb_idx;
          gnt_oh_d      = arb_oh;
          s_operation_d = m_operation[arb_idx];
          s_addr_d      = m_addr[arb_idx];
          s_wdata_d     = m_wdata[arb_idx];
          s_request_d   = 1'b1;
          state_d       = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (s_valid) begin
          m_rdata_d   = s_rdata;
          m_evict_d   = gnt_oh & {NUM_CH{s_evict}};
          m_valid_d   = gnt_oh;
          s_request_d = 1'b0;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        // Both sides must return to zero before the channel is released.
        if (!m_request[grant_id] && !s_valid) begin
          m_valid_d = '0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      last_grant  <= ID_W'(NUM_CH - 1);
      grant_id    <= '0;
      gnt_oh      <= '0;
      m_valid     <= '0;
      m_evict     <= '0;
      m_rdata     <= '0;
      s_request   <= 1'b0;
      s_operation <= NOP_INST;
      s_addr      <= '0;
      s_wdata     <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      last_grant  <= last_grant_d;
      grant_id    <= grant_id_d;
      gnt_oh      <= gnt_oh_d;
      m_valid     <= m_valid_d;
      m_evict     <= m_evict_d;
      m_rdata     <= m_rdata_d;
      s_request   <= s_request_d;
      s_operation <= s_operation_d;
      s_addr      <= s_addr_d;
      s_wdata     <= s_wdata_d;
      busy        <= busy_d;
    end
  end

endmodule
